// File: rtl/port_io_master.sv
`timescale 1ns/1ps
// Port I/O master: runs a fixed slot frame on a shared 8-bit bus, sending each
// port's direction and output shadow registers downstream and capturing the
// port's input value back. A small host register file gives access to the
// shadows, the captured inputs and a capture status byte.
module port_io_master #(
  parameter int NPORT     = 3,
  parameter int FRAME_LEN = 11
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] data,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  input  logic       wr,
  input  logic       rd,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       frame_start
);

  localparam int SW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_DIR,
    SLOT_READ,
    SLOT_WRITE
  } slot_kind_t;

  // Slot 0 is idle, then three slots per port (DIR, READ, WRITE), rest idle.
  function automatic slot_kind_t kind_of(input logic [SW-1:0] s);
    int idx;
    idx = int'(s);
    if (idx < 1 || idx > 3 * NPORT) begin
      return SLOT_IDLE;
    end
    case ((idx - 1) % 3)
      0:       return SLOT_DIR;
      1:       return SLOT_READ;
      default: return SLOT_WRITE;
    endcase
  endfunction

  // Port index owning a slot; meaningless for idle slots.
  function automatic logic [1:0] port_of(input logic [SW-1:0] s);
    int idx;
    idx = int'(s);
    if (idx < 1 || idx > 3 * NPORT) begin
      return 2'd0;
    end
    return 2'((idx - 1) / 3);
  endfunction

  logic [SW-1:0] slot_reg;
  logic [SW-1:0] slot_next;
  slot_kind_t    cur_kind;
  slot_kind_t    next_kind;
  logic [1:0]    cur_port;
  logic [1:0]    next_port;

  logic          oe_reg;
  logic [1:0]    sel_port_reg;
  logic          sel_out_reg;
  logic [7:0]    drive_val;

  logic [7:0]    dir_val [4];
  logic [7:0]    out_val [4];
  logic [7:0]    in_val  [4];
  logic [3:0]    in_valid;

  logic [7:0]    read_val;
  logic [7:0]    rdata_reg;
  logic          rvalid_reg;

  assign slot_next = (slot_reg == LAST_SLOT) ? '0 : slot_reg + 1'b1;

  // Decode both the current slot (for capture) and the upcoming slot (for the
  // registered bus control).
  always_comb begin
    cur_kind  = kind_of(slot_reg);
    cur_port  = port_of(slot_reg);
    next_kind = kind_of(slot_next);
    next_port = port_of(slot_next);
  end

  // Free-running slot counter, restarted by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg <= '0;
    end else begin
      slot_reg <= slot_next;
    end
  end

  // Bus enable and source select are registered from the upcoming slot so the
  // enable changes only on clock edges and lines up with slot_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_reg       <= 1'b0;
      sel_port_reg <= 2'd0;
      sel_out_reg  <= 1'b0;
    end else begin
      oe_reg       <= (next_kind == SLOT_DIR) || (next_kind == SLOT_WRITE);
      sel_port_reg <= next_port;
      sel_out_reg  <= (next_kind == SLOT_WRITE);
    end
  end

  // The driven value comes straight from the shadow registers, so a host
  // write landing at the end of a slot only shows up in a later slot.
  always_comb begin
    drive_val = sel_out_reg ? out_val[sel_port_reg] : dir_val[sel_port_reg];
  end

  assign data = (oe_reg && !rst) ? drive_val : 8'hzz;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      if (gi < NPORT) begin : g_live
        logic [7:0] dir_reg;
        logic [7:0] out_reg;
        logic [7:0] in_reg;
        logic       valid_reg;

        // Host writes into this port's direction and output shadows.
        always_ff @(posedge clk) begin
          if (rst) begin
            dir_reg <= 8'h00;
            out_reg <= 8'h00;
          end else if (wr) begin
            if (addr == 4'(gi)) begin
              dir_reg <= wdata;
            end
            if (addr == 4'(4 + gi)) begin
              out_reg <= wdata;
            end
          end
        end

        // Capture the bus on the edge that closes this port's READ slot.
        always_ff @(posedge clk) begin
          if (rst) begin
            in_reg    <= 8'h00;
            valid_reg <= 1'b0;
          end else if (cur_kind == SLOT_READ && cur_port == 2'(gi)) begin
            in_reg    <= data;
            valid_reg <= 1'b1;
          end
        end

        assign dir_val[gi]  = dir_reg;
        assign out_val[gi]  = out_reg;
        assign in_val[gi]   = in_reg;
        assign in_valid[gi] = valid_reg;
      end else begin : g_absent
        assign dir_val[gi]  = 8'h00;
        assign out_val[gi]  = 8'h00;
        assign in_val[gi]   = 8'h00;
        assign in_valid[gi] = 1'b0;
      end
    end
  endgenerate

  // Host register map: groups of four addresses for DIR, OUT, IN; STATUS at 12.
  // Absent ports read as zero through the tied-off entries above.
  always_comb begin
    read_val = 8'h00;
    case (addr[3:2])
      2'd0: read_val = dir_val[addr[1:0]];
      2'd1: read_val = out_val[addr[1:0]];
      2'd2: read_val = in_val[addr[1:0]];
      default: begin
        if (addr[1:0] == 2'd0) begin
          read_val = {4'b0000, in_valid};
        end
      end
    endcase
  end

  // Host read port: one cycle of latency, data held between reads. Reading
  // before this edge's writes/captures land gives pre-update values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg  <= 8'h00;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= rd;
      if (rd) begin
        rdata_reg <= read_val;
      end
    end
  end

  assign rdata       = rdata_reg;
  assign rvalid      = rvalid_reg;
  assign frame_start = (slot_reg == '0) && !rst;

endmodule

// File: tb/tb_port_io_master.sv
`timescale 1ns/1ps
// Bench for port_io_master: a slot-level reference model tracks the frame,
// the shadow/input registers and expected host reads; a monitor compares the
// bus, frame_start and read responses on every falling edge.
module tb_port_io_master;
  localparam int NPORT     = 3;
  localparam int FRAME_LEN = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid;
  logic       frame_start;
  wire  [7:0] data;

  logic       dn_en;
  logic [7:0] dn_drv;

  assign data = dn_en ? dn_drv : 8'hzz;

  for (genvar gi = 0; gi < 8; gi++) begin : g_pull
    pullup pu (data[gi]);
  end

  port_io_master #(.NPORT(NPORT), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .addr(addr),
    .wdata(wdata),
    .wr(wr),
    .rd(rd),
    .rdata(rdata),
    .rvalid(rvalid),
    .frame_start(frame_start)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  // Reference model state
  int         model_slot;
  logic [7:0] dir_m [3];
  logic [7:0] out_m [3];
  logic [7:0] in_m  [3];
  logic [2:0] valid_m;
  logic [7:0] exp_q [$];
  logic [7:0] hold_m;
  bit         started;
  bit         force_en;
  logic [7:0] force_val;
  int         checks;
  int         errors;

  // 0 idle, 1 DIR, 2 READ, 3 WRITE
  function automatic int kind_of_slot(input int s);
    if (s < 1 || s > 3 * NPORT) return 0;
    return 1 + (s - 1) % 3;
  endfunction

  function automatic logic [7:0] model_read(input logic [3:0] a);
    int grp;
    int p;
    grp = int'(a) / 4;
    p   = int'(a) % 4;
    if (grp == 3) return (p == 0) ? {5'b00000, valid_m} : 8'h00;
    if (p >= NPORT) return 8'h00;
    case (grp)
      0:       return dir_m[p];
      1:       return out_m[p];
      default: return in_m[p];
    endcase
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [7:0] v);
    int grp;
    int p;
    grp = int'(a) / 4;
    p   = int'(a) % 4;
    if (p < NPORT) begin
      if (grp == 0) dir_m[p] = v;
      if (grp == 1) out_m[p] = v;
    end
  endtask

  // Applied at each rising edge: reads see pre-edge state, then captures and
  // writes land, then the slot advances.
  task automatic model_update();
    int p;
    if (rst) begin
      model_slot = 0;
      for (int i = 0; i < 3; i++) begin
        dir_m[i] = 8'h00;
        out_m[i] = 8'h00;
        in_m[i]  = 8'h00;
      end
      valid_m = 3'b000;
      hold_m  = 8'h00;
      started = 1'b1;
    end else begin
      if (rd) exp_q.push_back(model_read(addr));
      if (kind_of_slot(model_slot) == 2) begin
        p = (model_slot - 1) / 3;
        in_m[p]    = dn_drv;
        valid_m[p] = 1'b1;
      end
      if (wr) model_write(addr, wdata);
      model_slot = (model_slot + 1) % FRAME_LEN;
    end
  endtask

  // Downstream block answers in every READ slot.
  task automatic set_downstream();
    if (kind_of_slot(model_slot) == 2) begin
      dn_en  = 1'b1;
      dn_drv = force_en ? force_val : 8'($urandom);
    end else begin
      dn_en = 1'b0;
    end
  endtask

  task automatic tick(input logic r, input logic w, input logic d,
                      input logic [3:0] a, input logic [7:0] wd);
    rst   = r;
    wr    = w;
    rd    = d;
    addr  = a;
    wdata = wd;
    @(posedge clk);
    model_update();
    #1;
    set_downstream();
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic goto_slot(input int s);
    for (int i = 0; i < FRAME_LEN && model_slot != s; i++) idle();
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h (slot %0d, t=%0t)",
               name, act, exp, model_slot, $time);
    end
  endtask

  // Monitor: compare outputs mid-cycle against the model and the read queue.
  initial begin
    int         k;
    logic [7:0] exp_bus;
    logic [7:0] exp_rd;
    forever begin
      @(negedge clk);
      if (started) begin
        k = kind_of_slot(model_slot);
        if (dn_en)                exp_bus = dn_drv;
        else if (!rst && k == 1)  exp_bus = dir_m[(model_slot - 1) / 3];
        else if (!rst && k == 3)  exp_bus = out_m[(model_slot - 1) / 3];
        else                      exp_bus = 8'hFF;
        check("bus", data, exp_bus);
        check("frame_start", {7'b0, frame_start}, {7'b0, (model_slot == 0 && !rst)});
        if (exp_q.size() > 0) begin
          exp_rd = exp_q.pop_front();
          check("rvalid", {7'b0, rvalid}, 8'h01);
          check("rdata", rdata, exp_rd);
          hold_m = exp_rd;
          $display("rd t=%0t rdata=%02h expected=%02h", $time, rdata, exp_rd);
        end else begin
          check("rvalid_idle", {7'b0, rvalid}, 8'h00);
          check("rdata_hold", rdata, hold_m);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = 4'd0; wdata = 8'h00;
    dn_en = 1'b0; dn_drv = 8'h00; force_en = 1'b0; force_val = 8'h00;
    checks = 0; errors = 0; hold_m = 8'h00; model_slot = 0; valid_m = 3'b000;
    started = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dir_m[i] = 8'h00; out_m[i] = 8'h00; in_m[i] = 8'h00;
    end

    repeat (3) tick(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    // Idle frames: zero shadows driven, READ/idle slots released.
    repeat (22) idle();

    // DIR0/OUT0 written just before slot 1 appear in the same frame.
    goto_slot(10);
    tick(1'b0, 1'b1, 1'b0, 4'd4, 8'hA5);
    tick(1'b0, 1'b1, 1'b0, 4'd0, 8'hFF);
    repeat (11) idle();

    // Downstream value 3C captured into IN1; read back plus STATUS.
    force_val = 8'h3C;
    force_en  = 1'b1;
    goto_slot(6);
    force_en  = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 4'd9, 8'h00);
    tick(1'b0, 1'b0, 1'b1, 4'd12, 8'h00);

    // Read of IN1 in its own capture slot returns the previous value.
    goto_slot(5);
    tick(1'b0, 1'b0, 1'b1, 4'd9, 8'h00);
    tick(1'b0, 1'b0, 1'b1, 4'd9, 8'h00);

    // Write OUT1 coincident with its WRITE slot.
    goto_slot(6);
    tick(1'b0, 1'b1, 1'b0, 4'd5, 8'h11);
    repeat (22) idle();

    // Reset mid-frame with host strobes that must be ignored.
    tick(1'b0, 1'b1, 1'b0, 4'd6, 8'h77);
    goto_slot(7);
    tick(1'b1, 1'b1, 1'b1, 4'd4, 8'h99);
    tick(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tick(1'b0, 1'b0, 1'b1, 4'd6, 8'h00);
    tick(1'b0, 1'b0, 1'b1, 4'd4, 8'h00);

    // Simultaneous write and read of the same register.
    tick(1'b0, 1'b1, 1'b1, 4'd0, 8'h5A);
    tick(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);

    // Unmapped and read-only addresses.
    tick(1'b0, 1'b0, 1'b1, 4'd13, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 4'd8, 8'hEE);
    tick(1'b0, 1'b0, 1'b1, 4'd8, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 4'd12, 8'hFF);
    tick(1'b0, 1'b0, 1'b1, 4'd12, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 4'd7, 8'h42);
    tick(1'b0, 1'b0, 1'b1, 4'd7, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 4'd3, 8'h43);
    tick(1'b0, 1'b0, 1'b1, 4'd3, 8'h00);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      tick(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           8'($urandom));
    end

    repeat (3) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
